// File: rtl/vpu_operand_queue_pkg.sv
// Shared VPU constants used by the operand queue and its interface.
package vpu_operand_queue_pkg;
   localparam int SRAM_DATA_WIDTH         = 32;
   localparam int OPERAND_QUEUE_DEPTH     = 8;
   localparam int OPERAND_QUEUE_CNT_WIDTH = $clog2(OPERAND_QUEUE_DEPTH) + 1;
endpackage

// File: rtl/vpu_operand_queue_if.sv
// Write-beat, FWFT read handshake and status bundle of one operand queue.
interface vpu_operand_queue_if import vpu_operand_queue_pkg::*; #(
   parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
   parameter int DEPTH      = OPERAND_QUEUE_DEPTH
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  wren_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  flush_i;
   logic                  rready_i;
   logic                  rvalid_o;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic [CW-1:0]         count_o;
   logic                  empty_o;
   logic                  full_o;
   logic                  almost_full_o;
   logic                  overflow_o;

   modport slave (
      input  wren_i, wdata_i, flush_i, rready_i,
      output rvalid_o, rdata_o, count_o, empty_o, full_o, almost_full_o, overflow_o
   );

   modport master (
      output wren_i, wdata_i, flush_i, rready_i,
      input  rvalid_o, rdata_o, count_o, empty_o, full_o, almost_full_o, overflow_o
   );
endinterface

// File: rtl/vpu_operand_queue_ram.sv
// Operand storage: one write port, one asynchronous read port, contents not reset.
module vpu_operand_queue_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/vpu_operand_queue.sv
// Operand FIFO between the source-port controller and the execution datapath:
// no write backpressure, FWFT read side, occupancy/almost-full status, sticky overflow.
module vpu_operand_queue import vpu_operand_queue_pkg::*; #(
   parameter int DATA_WIDTH   = SRAM_DATA_WIDTH,
   parameter int DEPTH        = OPERAND_QUEUE_DEPTH,
   parameter int AFULL_MARGIN = 2
) (
   input logic               clk,
   input logic               rst_n,
   vpu_operand_queue_if.slave q
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          ovf_q, ovf_d;
   logic [PW-1:0] count;
   logic          empty, full, pop, push, drop;

   // Pointers carry a wrap bit, so the plain difference is the occupancy.
   assign count = wptr_q - rptr_q;
   assign empty = (count == '0);
   assign full  = (count == PW'(DEPTH));
   assign pop   = !empty & q.rready_i;
   assign push  = q.wren_i & (!full | pop);
   assign drop  = q.wren_i & full & !pop;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;
      if (q.flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
         ovf_d  = 1'b0;
      end else begin
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         if (drop) ovf_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
      end
   end

   vpu_operand_queue_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .AW        (AW)
   ) u_ram (
      .clk    (clk),
      .we_i   (push & !q.flush_i),
      .waddr_i(wptr_q[AW-1:0]),
      .wdata_i(q.wdata_i),
      .raddr_i(rptr_q[AW-1:0]),
      .rdata_o(q.rdata_o)
   );

   assign q.rvalid_o      = !empty;
   assign q.count_o       = count;
   assign q.empty_o       = empty;
   assign q.full_o        = full;
   assign q.almost_full_o = (count >= PW'(DEPTH - AFULL_MARGIN));
   assign q.overflow_o    = ovf_q;
endmodule

// File: tb/tb_vpu_operand_queue.sv
// Bench for vpu_operand_queue: queue-based reference model compared every cycle, plus directed literal checks.
module tb_vpu_operand_queue;
   import vpu_operand_queue_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int AFM   = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vpu_operand_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) qif ();

   vpu_operand_queue #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .AFULL_MARGIN(AFM)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .q    (qif.slave)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] mq [$];
   bit            movf = 1'b0;
   bit            m_pop, m_full;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an unbounded queue trimmed by the occupancy rules.
   always @(posedge clk) begin
      if (!rst_n || qif.flush_i) begin
         mq.delete();
         movf = 1'b0;
      end else begin
         m_pop  = (mq.size() > 0) && qif.rready_i;
         m_full = (mq.size() == DEPTH);
         if (qif.wren_i && m_full && !m_pop) movf = 1'b1;
         if (m_pop) void'(mq.pop_front());
         if (qif.wren_i && (!m_full || m_pop)) mq.push_back(qif.wdata_i);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("count", 64'(qif.count_o), 64'(mq.size()));
         chk("empty", 64'(qif.empty_o), 64'(mq.size() == 0));
         chk("full", 64'(qif.full_o), 64'(mq.size() == DEPTH));
         chk("afull", 64'(qif.almost_full_o), 64'(mq.size() >= DEPTH - AFM));
         chk("rvalid", 64'(qif.rvalid_o), 64'(mq.size() != 0));
         chk("overflow", 64'(qif.overflow_o), 64'(movf));
         if (mq.size() > 0) chk("rdata", 64'(qif.rdata_o), 64'(mq[0]));
      end
   end

   task automatic tick(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
      qif.wren_i   = w;
      qif.wdata_i  = d;
      qif.rready_i = r;
      qif.flush_i  = f;
      @(negedge clk);
      qif.wren_i   = 1'b0;
      qif.rready_i = 1'b0;
      qif.flush_i  = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"}, 64'(qif.count_o), 64'd0);
      chk({tag, "_empty"}, 64'(qif.empty_o), 64'd1);
      chk({tag, "_full"}, 64'(qif.full_o), 64'd0);
      chk({tag, "_afull"}, 64'(qif.almost_full_o), 64'd0);
      chk({tag, "_rvalid"}, 64'(qif.rvalid_o), 64'd0);
      chk({tag, "_ovf"}, 64'(qif.overflow_o), 64'd0);
   endtask

   initial begin
      qif.wren_i   = 1'b0;
      qif.wdata_i  = '0;
      qif.rready_i = 1'b0;
      qif.flush_i  = 1'b0;
      rst_n        = 1'b0;
      @(negedge clk);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      chk_reset_state("rst");

      // Basic flow
      tick(1, 32'hA5, 0, 0);
      chk("basic_rvalid", 64'(qif.rvalid_o), 64'd1);
      chk("basic_rdata", 64'(qif.rdata_o), 64'hA5);
      chk("basic_count", 64'(qif.count_o), 64'd1);
      tick(0, 0, 1, 0);
      chk("basic_empty", 64'(qif.empty_o), 64'd1);

      // Fill, overflow, order
      for (int i = 0; i < DEPTH; i++) begin
         tick(1, DW'(i), 0, 0);
         chk("fill_afull", 64'(qif.almost_full_o), 64'(i + 1 >= 6));
      end
      chk("fill_full", 64'(qif.full_o), 64'd1);
      tick(1, 32'h99, 0, 0);
      chk("ovf_set", 64'(qif.overflow_o), 64'd1);
      chk("ovf_count", 64'(qif.count_o), 64'd8);
      for (int i = 0; i < DEPTH; i++) begin
         chk("order", 64'(qif.rdata_o), 64'(i));
         tick(0, 0, 1, 0);
      end
      chk("drain_empty", 64'(qif.empty_o), 64'd1);
      chk("ovf_sticky", 64'(qif.overflow_o), 64'd1);
      tick(0, 0, 0, 1);
      chk("flush_ovf", 64'(qif.overflow_o), 64'd0);

      // Full with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) tick(1, DW'(32'h100 + i), 0, 0);
      tick(1, 32'h77, 1, 0);
      chk("pp_count", 64'(qif.count_o), 64'd8);
      chk("pp_ovf", 64'(qif.overflow_o), 64'd0);
      for (int i = 1; i < DEPTH; i++) begin
         chk("pp_order", 64'(qif.rdata_o), 64'(32'h100 + i));
         tick(0, 0, 1, 0);
      end
      chk("pp_new", 64'(qif.rdata_o), 64'h77);
      tick(0, 0, 1, 0);
      chk("pp_empty", 64'(qif.empty_o), 64'd1);

      // Streaming with pointer wrap
      tick(1, 32'd1, 0, 0);
      for (int i = 2; i <= 20; i++) begin
         chk("stream_data", 64'(qif.rdata_o), 64'(i - 1));
         tick(1, DW'(i), 1, 0);
         chk("stream_cnt", 64'(qif.count_o <= 1), 64'd1);
      end
      chk("stream_last", 64'(qif.rdata_o), 64'd20);
      tick(0, 0, 1, 0);
      chk("stream_empty", 64'(qif.empty_o), 64'd1);

      // Flush priority
      for (int i = 0; i < DEPTH; i++) tick(1, DW'(32'h200 + i), 0, 0);
      tick(1, 32'h99, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
      chk("fl_pre_count", 64'(qif.count_o), 64'd5);
      chk("fl_pre_ovf", 64'(qif.overflow_o), 64'd1);
      tick(1, 32'hEE, 1, 1);
      chk("fl_count", 64'(qif.count_o), 64'd0);
      chk("fl_empty", 64'(qif.empty_o), 64'd1);
      chk("fl_ovf", 64'(qif.overflow_o), 64'd0);
      tick(0, 0, 0, 0);
      chk("fl_absent", 64'(qif.empty_o), 64'd1);

      // Reset mid-stream
      for (int i = 0; i < 3; i++) tick(1, DW'(32'h300 + i), 0, 0);
      chk("mr_count", 64'(qif.count_o), 64'd3);
      rst_n = 1'b0;
      tick(1, 32'h55, 1, 0);
      rst_n = 1'b1;
      chk_reset_state("mr");
      tick(1, 32'h3C, 0, 0);
      chk("mr_rdata", 64'(qif.rdata_o), 64'h3C);
      chk("mr_cnt1", 64'(qif.count_o), 64'd1);
      tick(0, 0, 1, 0);
      chk("mr_empty", 64'(qif.empty_o), 64'd1);

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         bit w, r, f;
         w = ($urandom_range(0, 99) < 60);
         r = ($urandom_range(0, 99) < 55);
         f = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
         tick(w, DW'($urandom), r, f);
         rst_n = 1'b1;
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vpu_operand_queue.md
# vpu_operand_queue

Operand buffer between a VPU source-port controller and the VPU execution datapath. Captures one SRAM read beat per cycle from the source-port controller's `operand_fifo_wren`/`operand_fifo_wdata` outputs and presents operands first-word-fall-through on a valid/ready interface. The write side has no backpressure, so the queue also provides:
- occupancy and almost-full status, which the VPU controller uses to gate `start_i`;
- a sticky overflow error.

## Interface
Parameters:
- `DATA_WIDTH`, default `VPU_PKG::SRAM_DATA_WIDTH`: operand width in bits.
- `DEPTH`, default `VPU_PKG::OPERAND_QUEUE_DEPTH` (8): entry count. Must be a power of two and at least 2.
- `AFULL_MARGIN`, default 2: `almost_full_o` asserts when `count_o >= DEPTH - AFULL_MARGIN`. Legal range 1 to DEPTH-1.

Ports (reset is rst_n, synchronous, active-low; clock is clk):
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `wren_i`  in  1  write strobe from the source-port controller.
- `wdata_i`  in  DATA_WIDTH  write data, sampled when `wren_i` is high.
- `flush_i`  in  1  synchronous clear of contents and error.
- `rvalid_o`  out  1  head entry valid.
- `rdata_o`  out  DATA_WIDTH  head entry data.
- `rready_i`  in  1  consumer accepts the head entry.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.
- `empty_o`  out  1  `count_o == 0`.
- `full_o`  out  1  `count_o == DEPTH`.
- `almost_full_o`  out  1  occupancy threshold flag.
- `overflow_o`  out  1  sticky: a write was dropped.

## Operation
Pointers and occupancy:
- Storage is a flop array of DEPTH x DATA_WIDTH.
- Write and read pointers are $clog2(DEPTH)+1 bits wide. The extra MSB is a wrap bit.
- `count_o` is the registered difference `wptr - rptr`.
- Pointers wrap naturally modulo 2*DEPTH. The index is the low $clog2(DEPTH) bits.

Read side:
- pop = `rvalid_o & rready_i`.
- `rvalid_o` = `!empty_o`.
- `rdata_o` = `mem[rptr index]`. It is a combinational read of registered storage.
- `rdata_o` is don't-care while empty. The bench must not check it then.

Write side:
- push = `wren_i & (!full_o | pop)`.
- When full, a write in the same cycle as a pop is accepted.
- drop = `wren_i & full_o & !pop`. On drop, data is discarded, the pointers are unchanged and `overflow_o` sets.

Count update:
- push and pop together: count unchanged, both pointers advance.
- push only: count +1.
- pop only: count -1.

Empty case:
- When empty, `rready_i` has no effect.
- A write while empty is accepted. It is not bypassed to the output in the same cycle.

Flush:
- `flush_i` has priority over everything.
- Next cycle: pointers are 0, count is 0 and `overflow_o` is 0.
- A write or pop in the flush cycle is ignored.

`overflow_o` clears only on reset or flush.

## Timing
- Reset values: `count_o`=0, `empty_o`=1, `full_o`=0, `almost_full_o`=0, `rvalid_o`=0, `overflow_o`=0. Pointers are 0. Storage contents are not reset.
- Write-to-read latency is 1 cycle. After `wren_i` in cycle N into an empty queue, `rvalid_o` and `rdata_o` are valid in cycle N+1.
- Pop takes effect at the clock edge. The next entry appears on `rdata_o` in the following cycle with no bubble. Sustained throughput is 1 entry per cycle in and out.
- All status outputs are registered-state derived. They change only one cycle after the causing event.
- Reset mid-operation is equivalent to flush: contents are lost and no partial state survives.

## Structure
- The `VPU_PKG` shared package holds:
  - `OPERAND_QUEUE_DEPTH`;
  - `OPERAND_QUEUE_CNT_WIDTH` = $clog2(OPERAND_QUEUE_DEPTH)+1;
  - `SRAM_DATA_WIDTH`, which already exists.
- Single module, roughly 150–200 lines. No sub-module is required.
- If the flop array is later swapped for a macro, isolate it as `vpu_operand_queue_ram`: 1 write port, 1 async read port.
- One instance per source port. The execution datapath ANDs the `rvalid_o` of all operand queues before issuing.

## Test plan
- **Reset and basic flow.** Reset, then write 0xA5 (zero-extended) with `rready_i`=0 → next cycle `rvalid_o`=1, `rdata_o`=0xA5, `count_o`=1. Then assert `rready_i` → following cycle `empty_o`=1.
- **Fill, overflow and order.** With DEPTH=8, write 8 beats 0..7 with no reads → `full_o`=1, `almost_full_o` asserted from `count_o`=6. A 9th write (0x99) → `overflow_o`=1, `count_o`=8. Reads then return 0..7 in order with no 0x99.
- **Full plus simultaneous push/pop.** With the queue full, `wren_i` plus `rready_i` in the same cycle → `count_o` stays 8, `overflow_o` stays 0, and the new data appears after the 7 remaining older entries.
- **Streaming wrap-around.** Write 20 beats 1..20 at one per cycle with `rready_i`=1 from the cycle after the first write → reads 1..20 in order, `count_o` never exceeds 1, and pointers wrap twice.
- **Flush priority.** With 5 entries and `overflow_o`=1, assert `flush_i` together with `wren_i` and `rready_i` → next cycle `count_o`=0, `empty_o`=1, `overflow_o`=0, and the flushed write is absent.
- **Reset mid-stream.** With 3 entries, pulse `rst_n`=0 for one cycle → all outputs return to reset values, and the next write/read round-trips correctly.
